mc_main_control: RTL and testbench

- Multicycle MIPS main control FSM.
- Decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the 2-bit alu_op consumed by aluControlUnit (00 add, 01 subtract/compare, 10 use funct), plus all datapath mux, write-enable and memory strobes.
- Sits beside aluControlUnit in the multicycle CPU top; memory accesses wait on a mem_ready handshake.

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_if.sv | 34 +++
 rtl/mc_ctrl_decode.sv | 76 +++++++
 rtl/mc_main_control.sv | 109 ++++++++++
 tb/tb_mc_main_control.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcodes, ALU op codes, datapath select codes, state encodings, control word.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC      = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_ILLEGAL   = 4'd13
    } state_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'(17'd0);

endpackage

// File: rtl/mc_if.sv
// Control bus between the main control FSM (master) and the datapath/memory (slave).
interface mc_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (and mem_ready, for the FETCH IR/PC load)
// to the datapath control word. Unlisted or unreachable states give all zeros.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_word_t ctrl_o
);

    // Control word per state
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALU_OUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register and next-state logic;
// the control word is decoded from the state by mc_ctrl_decode.
module mc_main_control
    import mc_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    mc_if.master bus
);

    state_e     state_q;
    state_e     state_d;
    ctrl_word_t ctrl_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable codes fall back to RST
    always_comb begin
        state_d = ST_RST;
        case (state_q)
            ST_RST:       state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) begin
                            state_d = ST_ADDI_EXEC;
                        end else begin
                            state_d = ST_ILLEGAL;
                        end
                    end
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = ST_MEM_READ;
                end else begin
                    state_d = ST_MEM_WRITE;
                end
            end
            ST_MEM_READ: begin
                if (bus.mem_ready) begin
                    state_d = ST_MEM_WB;
                end else begin
                    state_d = ST_MEM_READ;
                end
            end
            ST_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM_WRITE;
                end
            end
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_EXEC:      state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_ADDI_WB:   state_d = ST_FETCH;
            ST_ILLEGAL:   state_d = ST_ILLEGAL;
            default:      state_d = ST_RST;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl_s)
    );

    assign bus.alu_op        = ctrl_s.alu_op;
    assign bus.alu_src_a     = ctrl_s.alu_src_a;
    assign bus.alu_src_b     = ctrl_s.alu_src_b;
    assign bus.pc_source     = ctrl_s.pc_source;
    assign bus.pc_write      = ctrl_s.pc_write;
    assign bus.pc_write_cond = ctrl_s.pc_write_cond;
    assign bus.i_or_d        = ctrl_s.i_or_d;
    assign bus.mem_read      = ctrl_s.mem_read;
    assign bus.mem_write     = ctrl_s.mem_write;
    assign bus.ir_write      = ctrl_s.ir_write;
    assign bus.reg_dst       = ctrl_s.reg_dst;
    assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
    assign bus.reg_write     = ctrl_s.reg_write;
    assign bus.illegal       = ctrl_s.illegal;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven bench for mc_main_control: instruction sequences,
// memory waits, illegal opcode, ENABLE_ADDI=0 and asynchronous reset abort.
module tb_mc_main_control;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_if bus ();
    mc_if bus0 ();

    mc_main_control #(.ENABLE_ADDI(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mc_main_control #(.ENABLE_ADDI(1'b0)) dut_noaddi (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // Packed view of the control outputs:
    // {alu_op, src_a, src_b, pc_src, pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, illegal}
    logic [16:0] w_s;
    assign w_s = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.pc_write,
                  bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal};

    localparam logic [16:0] W_RST     = 17'd0;
    localparam logic [16:0] W_FETCH_R = {2'b00,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_FETCH_W = {2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_DECODE  = {2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_MADDR   = {2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_MREAD   = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_MWB     = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    localparam logic [16:0] W_MWRITE  = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_EXEC    = {2'b10,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_RWB     = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    localparam logic [16:0] W_BRANCH  = {2'b01,1'b1,2'b00,2'b01,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_JUMP    = {2'b00,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_AEXEC   = {2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] W_AWB     = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [16:0] W_ILL     = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [16:0] exp_w;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp_val(input string name, input int idx, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then step past the next rising edge
    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] es,
                        input logic [16:0] ew, input int idx);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        @(negedge clk);
        cmp_val("state", idx, {13'd0, bus.state}, {13'd0, es});
        cmp_val("ctrl", idx, w_s, ew);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] es, input logic [16:0] ew);
        vec_t v;
        v.op = op; v.rdy = rdy; v.exp_state = es; v.exp_w = ew;
        vecs.push_back(v);
    endtask

    initial begin
        bus.opcode     = 6'd0;
        bus.mem_ready  = 1'b0;
        bus0.opcode    = 6'b001000;
        bus0.mem_ready = 1'b1;
        rst_n          = 1'b0;

        // R-type, then lw with 2 FETCH waits and 3 MEM_READ waits
        add(6'h00, 1'b1, 4'd0,  W_RST);
        add(6'h00, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h00, 1'b0, 4'd2,  W_DECODE);
        add(6'h00, 1'b0, 4'd7,  W_EXEC);
        add(6'h00, 1'b1, 4'd8,  W_RWB);
        add(6'h23, 1'b0, 4'd1,  W_FETCH_W);
        add(6'h23, 1'b0, 4'd1,  W_FETCH_W);
        add(6'h23, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h23, 1'b0, 4'd2,  W_DECODE);
        add(6'h23, 1'b1, 4'd3,  W_MADDR);
        add(6'h23, 1'b0, 4'd4,  W_MREAD);
        add(6'h23, 1'b0, 4'd4,  W_MREAD);
        add(6'h23, 1'b0, 4'd4,  W_MREAD);
        add(6'h23, 1'b1, 4'd4,  W_MREAD);
        add(6'h23, 1'b0, 4'd5,  W_MWB);
        // sw, beq, j, addi back to back
        add(6'h2b, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h2b, 1'b1, 4'd2,  W_DECODE);
        add(6'h2b, 1'b1, 4'd3,  W_MADDR);
        add(6'h2b, 1'b1, 4'd6,  W_MWRITE);
        add(6'h04, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h04, 1'b1, 4'd2,  W_DECODE);
        add(6'h04, 1'b0, 4'd9,  W_BRANCH);
        add(6'h02, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h02, 1'b1, 4'd2,  W_DECODE);
        add(6'h02, 1'b0, 4'd10, W_JUMP);
        add(6'h08, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h08, 1'b1, 4'd2,  W_DECODE);
        add(6'h08, 1'b0, 4'd11, W_AEXEC);
        add(6'h08, 1'b0, 4'd12, W_AWB);
        // illegal opcode
        add(6'h3f, 1'b1, 4'd1,  W_FETCH_R);
        add(6'h3f, 1'b1, 4'd2,  W_DECODE);

        repeat (2) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        cmp_val("reset_state", 0, {13'd0, bus.state}, 17'd0);
        cmp_val("reset_ctrl", 0, w_s, W_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].rdy, vecs[i].exp_state, vecs[i].exp_w, i);
        end

        // ILLEGAL is absorbing regardless of inputs
        for (int k = 0; k < 20; k++) begin
            step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'd13, W_ILL, 100 + k);
        end

        // Reset pulse clears ILLEGAL immediately
        rst_n = 1'b0;
        #2;
        cmp_val("ill_rst_state", 0, {13'd0, bus.state}, 17'd0);
        cmp_val("ill_rst_flag", 0, {16'd0, bus.illegal}, 17'd0);
        rst_n = 1'b1;
        step(6'h23, 1'b1, 4'd0, W_RST, 200);
        step(6'h23, 1'b1, 4'd1, W_FETCH_R, 201);
        step(6'h23, 1'b1, 4'd2, W_DECODE, 202);
        step(6'h23, 1'b1, 4'd3, W_MADDR, 203);
        step(6'h23, 1'b1, 4'd4, W_MREAD, 204);

        // Asynchronous reset in the middle of MEM_WB
        bus.mem_ready = 1'b1;
        @(negedge clk);
        cmp_val("mwb_state", 0, {13'd0, bus.state}, 17'd5);
        cmp_val("mwb_reg_write", 0, {16'd0, bus.reg_write}, 17'd1);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_val("async_reg_write", 0, {16'd0, bus.reg_write}, 17'd0);
        cmp_val("async_state", 0, {13'd0, bus.state}, 17'd0);
        cmp_val("async_ctrl", 0, w_s, W_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(6'h00, 1'b1, 4'd0, W_RST, 300);
        step(6'h00, 1'b1, 4'd1, W_FETCH_R, 301);
        step(6'h00, 1'b1, 4'd2, W_DECODE, 302);
        step(6'h00, 1'b1, 4'd7, W_EXEC, 303);

        // The ENABLE_ADDI=0 instance saw addi with mem_ready=1 since release
        cmp_val("noaddi_state", 0, {13'd0, bus0.state}, 17'd13);
        cmp_val("noaddi_illegal", 0, {16'd0, bus0.illegal}, 17'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
